axi32_arb2: RTL
===============

# axi32_arb2

Two-master to one-slave arbiter for 32-bit single-beat AXI3-style traffic, as produced by Raccoon ring-to-AXI bridges. It shares one AXI slave port (memory or peripheral) between two bridges, arbitrating the write path and the read path independently with round-robin grants. It tags slave IDs with the master index and routes B/R responses back. It also caps outstanding transactions per direction.

## Interface
- MAX_OUTST, 4: maximum accepted-but-unanswered transactions per direction (reads, writes); legal 1..15.
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Mn_AWID/AWADDR/AWVALID  in  8/32/1  master n write address (n=0,1).
- Mn_AWREADY  out  1  master n write address accept.
- Mn_WDATA/WSTRB/WVALID  in  32/4/1  master n write data (single beat, WLAST implied).
- Mn_WREADY  out  1  master n write data accept.
- Mn_BID/BRESP/BVALID  out  8/2/1  master n write response.
- Mn_BREADY  in  1  master n write response accept.
- Mn_ARID/ARADDR/ARVALID  in  8/32/1  master n read address.
- Mn_ARREADY  out  1  master n read address accept.
- Mn_RID/RDATA/RRESP/RLAST/RVALID  out  8/32/2/1/1  master n read data.
- Mn_RREADY  in  1  master n read data accept.
- S_AWID/AWADDR/AWVALID  out  9/32/1  slave write address; S_AWID = {n, Mn_AWID}.
- S_AWREADY  in  1.
- S_WID/WDATA/WSTRB/WLAST/WVALID  out  9/32/4/1/1  slave write data; WID equals S_AWID, WLAST tied 1.
- S_WREADY  in  1.
- S_BID/BRESP/BVALID  in  9/2/1;  S_BREADY  out  1.
- S_ARID/ARADDR/ARVALID  out  9/32/1;  S_ARREADY  in  1.
- S_RID/RDATA/RRESP/RLAST/RVALID  in  9/32/2/1/1;  S_RREADY  out  1.
- Length/size/burst/lock/cache/prot are not carried: single beat, 4 bytes, tie-offs at the slave.

## Operation
- Write FSM states: WR_IDLE, WR_BUSY. Registered: wr_gnt (master index), aw_done, w_done, wr_last (last granted).
- WR_IDLE: candidates are Mn with Mn_AWVALID=1 and wr_cnt < MAX_OUTST. One candidate wins. Two candidates: the master != wr_last wins. Latch wr_gnt and clear aw_done/w_done, then go to WR_BUSY. W valid is not required for grant.
- WR_BUSY, granted master g:
  - S_AWVALID = Mg_AWVALID & !aw_done; Mg_AWREADY = S_AWREADY & !aw_done.
  - S_WVALID = Mg_WVALID & !w_done; Mg_WREADY = S_WREADY & !w_done.
  - The done flags set on their handshakes. When both are done (or both complete this cycle), go to WR_IDLE and set wr_last <= g.
  - The ungranted master sees READY=0 on all its request channels.
- Read FSM: RD_IDLE, RD_BUSY, rd_gnt, rd_last. Same arbitration on Mn_ARVALID and rd_cnt < MAX_OUTST.
  - RD_BUSY: S_ARVALID = Mg_ARVALID, Mg_ARREADY = S_ARREADY.
  - On AR handshake, return to RD_IDLE and set rd_last <= g.
- Response routing is combinational and stateless:
  - Mn_BVALID = S_BVALID & (S_BID[8]==n); Mn_BID = S_BID[7:0]; S_BREADY = M[S_BID[8]]_BREADY.
  - R routes the same way using S_RID[8].
- Counters are 4 bits each:
  - wr_cnt: +1 on S_AW handshake, -1 on S_B handshake, unchanged if both occur in the same cycle.
  - rd_cnt: +1 on S_AR handshake, -1 on S_R handshake with RLAST=1, unchanged if both occur.
  - Neither counter wraps; a counter at MAX_OUTST blocks new grants in that direction only.
- A B or R response arriving with a count of 0 is a slave protocol error. It is still routed, and the counter saturates at 0.

## Timing
- Reset values:
  - FSMs in IDLE; wr_last = rd_last = 1, so M0 wins the first tie; counters 0; done flags 0.
  - All S_*VALID = 0 and all Mn_*READY = 0.
  - Mn_BVALID/Mn_RVALID follow S_* combinationally and are 0 when the slave drives 0.
- Grant latency: Mn_AWVALID rising in cycle N (IDLE, not blocked) gives S_AWVALID=1 in cycle N+1. Minimum AW-to-next-grant cycle is 3 (IDLE, BUSY, IDLE).
- Reads: one AR per 2 cycles maximum.
- Write and read paths are fully independent; simultaneous grants in both are legal.
- S_* request outputs are combinational from the granted master's signals in BUSY; there is no extra register stage.
- The arbiter never withdraws a valid once asserted, provided the granted master holds VALID (AXI rule). The grant is held until handshake.
- RST mid-transaction aborts the FSMs and clears the counters immediately. The slave is reset on the same RST.

## Test plan
- Single write from M0 (AWID=0x12, addr 0x00010004, data 0xCAFEF00D, strb 0xF): S_AWID=0x012 at cycle 1 after request; BID 0x012 returns on M0_BVALID with M0_BID=0x12; M1_BVALID stays 0.
- M0 and M1 both present AR in the same cycle, repeated 4 times: grants alternate M0, M1, M0, M1; S_ARID[8] sequence 0,1,0,1.
- W presented 3 cycles after AW on M1: S_AWVALID accepted first, FSM stays WR_BUSY until the W handshake, then returns to IDLE; M0 AW is blocked meanwhile.
- MAX_OUTST=2 and the slave withholds R: the third AR is not granted (M_ARREADY=0) until one R with RLAST completes, then it is granted the next IDLE cycle.
- Simultaneous S_AR handshake and S_R completion at rd_cnt=2: the count stays 2. Concurrent read grant and write grant in the same cycle both proceed.
- Assert RST while in WR_BUSY with aw_done=1: all valids/readies drop immediately, counters read 0, and the first post-reset tie goes to M0.

Source files
------------

// File: rtl/axi32_arb2_if.sv
// Single-beat 32-bit AXI3-style port bundle; ID width differs between the
// master-facing side (8) and the slave-facing side (9, master index in the MSB).
interface axi32_arb2_if #(parameter int unsigned ID_W = 8);
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic            awvalid;
  logic            awready;
  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp,
           rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp,
           rlast, rvalid
  );
endinterface

// File: rtl/axi32_arb2.sv
// Two-master to one-slave AXI arbiter: independent round-robin write and read
// grants, master index tagged into the slave ID, outstanding-transaction caps.
module axi32_arb2 #(
  parameter int unsigned MAX_OUTST = 4
) (
  input logic         CLK,
  input logic         RST,
  axi32_arb2_if.slave  m0,
  axi32_arb2_if.slave  m1,
  axi32_arb2_if.master s
);
  localparam int unsigned ID_W  = 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_TOP = '1;

  typedef enum logic { WR_IDLE = 1'b0, WR_BUSY = 1'b1 } wr_state_e;
  typedef enum logic { RD_IDLE = 1'b0, RD_BUSY = 1'b1 } rd_state_e;

  wr_state_e        wr_state_q, wr_state_d;
  logic             wr_gnt_q, wr_gnt_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic             wr_last_q, wr_last_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  rd_state_e        rd_state_q, rd_state_d;
  logic             rd_gnt_q, rd_gnt_d;
  logic             rd_last_q, rd_last_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

  logic wr_busy, rd_busy;
  logic aw_vld, w_vld, ar_vld, aw_rdy, w_rdy, ar_rdy;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_cand0, wr_cand1, rd_cand0, rd_cand1;

  assign wr_busy = (wr_state_q == WR_BUSY);
  assign rd_busy = (rd_state_q == RD_BUSY);

  // Granted write master drives the slave request channels directly
  assign s.awid   = {wr_gnt_q, wr_gnt_q ? m1.awid : m0.awid};
  assign s.wid    = {wr_gnt_q, wr_gnt_q ? m1.awid : m0.awid};
  assign s.awaddr = wr_gnt_q ? m1.awaddr : m0.awaddr;
  assign s.wdata  = wr_gnt_q ? m1.wdata  : m0.wdata;
  assign s.wstrb  = wr_gnt_q ? m1.wstrb  : m0.wstrb;
  assign s.wlast  = 1'b1;

  assign aw_vld = wr_busy & ~aw_done_q & (wr_gnt_q ? m1.awvalid : m0.awvalid);
  assign w_vld  = wr_busy & ~w_done_q  & (wr_gnt_q ? m1.wvalid  : m0.wvalid);
  assign aw_rdy = wr_busy & ~aw_done_q & s.awready;
  assign w_rdy  = wr_busy & ~w_done_q  & s.wready;

  assign s.awvalid  = aw_vld;
  assign s.wvalid   = w_vld;
  assign m0.awready = aw_rdy & ~wr_gnt_q;
  assign m1.awready = aw_rdy &  wr_gnt_q;
  assign m0.wready  = w_rdy  & ~wr_gnt_q;
  assign m1.wready  = w_rdy  &  wr_gnt_q;

  assign s.arid    = {rd_gnt_q, rd_gnt_q ? m1.arid : m0.arid};
  assign s.araddr  = rd_gnt_q ? m1.araddr : m0.araddr;
  assign ar_vld    = rd_busy & (rd_gnt_q ? m1.arvalid : m0.arvalid);
  assign ar_rdy    = rd_busy & s.arready;
  assign s.arvalid  = ar_vld;
  assign m0.arready = ar_rdy & ~rd_gnt_q;
  assign m1.arready = ar_rdy &  rd_gnt_q;

  // Stateless response routing on the ID tag bit
  assign m0.bvalid = s.bvalid & ~s.bid[ID_W];
  assign m1.bvalid = s.bvalid &  s.bid[ID_W];
  assign m0.bid    = s.bid[ID_W-1:0];
  assign m1.bid    = s.bid[ID_W-1:0];
  assign m0.bresp  = s.bresp;
  assign m1.bresp  = s.bresp;
  assign s.bready  = s.bid[ID_W] ? m1.bready : m0.bready;

  assign m0.rvalid = s.rvalid & ~s.rid[ID_W];
  assign m1.rvalid = s.rvalid &  s.rid[ID_W];
  assign m0.rid    = s.rid[ID_W-1:0];
  assign m1.rid    = s.rid[ID_W-1:0];
  assign m0.rdata  = s.rdata;
  assign m1.rdata  = s.rdata;
  assign m0.rresp  = s.rresp;
  assign m1.rresp  = s.rresp;
  assign m0.rlast  = s.rlast;
  assign m1.rlast  = s.rlast;
  assign s.rready  = s.rid[ID_W] ? m1.rready : m0.rready;

  assign aw_hs = aw_vld & s.awready;
  assign w_hs  = w_vld & s.wready;
  assign b_hs  = s.bvalid & s.bready;
  assign ar_hs = ar_vld & s.arready;
  assign r_hs  = s.rvalid & s.rready & s.rlast;

  assign wr_cand0 = m0.awvalid & (wr_cnt_q < CNT_MAX);
  assign wr_cand1 = m1.awvalid & (wr_cnt_q < CNT_MAX);
  assign rd_cand0 = m0.arvalid & (rd_cnt_q < CNT_MAX);
  assign rd_cand1 = m1.arvalid & (rd_cnt_q < CNT_MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_state_q <= WR_IDLE;
      wr_gnt_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      wr_last_q  <= 1'b1;
      wr_cnt_q   <= '0;
      rd_state_q <= RD_IDLE;
      rd_gnt_q   <= 1'b0;
      rd_last_q  <= 1'b1;
      rd_cnt_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_gnt_q   <= wr_gnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      wr_last_q  <= wr_last_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_state_q <= rd_state_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_last_q  <= rd_last_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  // Write path: hold the grant until both AW and W have handshaken
  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    wr_last_d  = wr_last_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (wr_cand0 | wr_cand1) begin
          wr_gnt_d   = (wr_cand0 & wr_cand1) ? ~wr_last_q : wr_cand1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = WR_BUSY;
        end
      end
      WR_BUSY: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d & w_done_d) begin
          wr_state_d = WR_IDLE;
          wr_last_d  = wr_gnt_q;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_last_d  = rd_last_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_cand0 | rd_cand1) begin
          rd_gnt_d   = (rd_cand0 & rd_cand1) ? ~rd_last_q : rd_cand1;
          rd_state_d = RD_BUSY;
        end
      end
      RD_BUSY: begin
        if (ar_hs) begin
          rd_state_d = RD_IDLE;
          rd_last_d  = rd_gnt_q;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Saturating outstanding counters; a response at zero leaves the count at zero
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (aw_hs && !b_hs && wr_cnt_q != CNT_TOP)
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    else if (b_hs && !aw_hs && wr_cnt_q != '0)
      wr_cnt_d = wr_cnt_q - CNT_W'(1);
    if (ar_hs && !r_hs && rd_cnt_q != CNT_TOP)
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    else if (r_hs && !ar_hs && rd_cnt_q != '0)
      rd_cnt_d = rd_cnt_q - CNT_W'(1);
  end
endmodule
